// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared compare function codes and FSM state encoding
package alu_pkg;

  localparam logic [2:0] FT_NEQ = 3'b000;
  localparam logic [2:0] FT_EQ  = 3'b001;
  localparam logic [2:0] FT_LT  = 3'b010;
  localparam logic [2:0] FT_GEZ = 3'b100;
  localparam logic [2:0] FT_LEZ = 3'b110;
  localparam logic [2:0] FT_GTZ = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cmp_chunk_sub.sv
// rtl/cmp_chunk_sub.sv - one CHUNK-bit slice of a + ~b + cin
module cmp_chunk_sub #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] nb,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             slice_zero
);

  logic [CHUNK:0] s;

  assign s          = {1'b0, a} + {1'b0, nb} + {{CHUNK{1'b0}}, cin};
  assign sum        = s[CHUNK-1:0];
  assign cout       = s[CHUNK];
  assign slice_zero = (s[CHUNK-1:0] == '0);

endmodule

// File: rtl/cmp_flag_gen.sv
// rtl/cmp_flag_gen.sv - multi-cycle a-b subtractor producing compare flags
module cmp_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  input  logic [2:0]       ft,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             zero,
  output logic             overflow,
  output logic             negative,
  output logic [2:0]       ft_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zero_acc_q, zero_acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic             sign_q, sign_d;
  logic [2:0]       ft_q, ft_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;

  logic [CHUNK-1:0] a_slice, nb_slice, sum;
  logic             cout, slice_zero, v;

  assign a_slice  = a_q[cnt_q*CHUNK +: CHUNK];
  assign nb_slice = nb_q[cnt_q*CHUNK +: CHUNK];

  cmp_chunk_sub #(.CHUNK(CHUNK)) u_sub (
    .a          (a_slice),
    .nb         (nb_slice),
    .cin        (carry_q),
    .sum        (sum),
    .cout       (cout),
    .slice_zero (slice_zero)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    zero_acc_d = zero_acc_q;
    a_d        = a_q;
    nb_d       = nb_q;
    sign_d     = sign_q;
    ft_d       = ft_q;
    diff_d     = diff_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    neg_d      = neg_q;
    v          = 1'b0;
    // flush also blocks an accept while idle
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_d        = a;
            nb_d       = ~b;
            sign_d     = sign;
            ft_d       = ft;
            carry_d    = 1'b1;
            zero_acc_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_RUN;
          end
        end
        ST_RUN: begin
          diff_d[cnt_q*CHUNK +: CHUNK] = sum;
          carry_d    = cout;
          zero_acc_d = zero_acc_q & slice_zero;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            // the top slice sum holds diff's MSB; b's MSB is recovered from ~b
            v       = (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1]) & (a_q[WIDTH-1] ^ sum[CHUNK-1]);
            cnt_d   = '0;
            zero_d  = zero_acc_q & slice_zero;
            ovf_d   = sign_q & v;
            neg_d   = sign_q ? (sum[CHUNK-1] ^ v) : ~cout;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b1;
      zero_acc_q <= 1'b1;
      a_q        <= '0;
      nb_q       <= '0;
      sign_q     <= 1'b0;
      ft_q       <= '0;
      diff_q     <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      zero_acc_q <= zero_acc_d;
      a_q        <= a_d;
      nb_q       <= nb_d;
      sign_q     <= sign_d;
      ft_q       <= ft_d;
      diff_q     <= diff_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      neg_q      <= neg_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign negative  = neg_q;
  assign ft_out    = ft_q;

endmodule

// File: tb/tb_cmp_flag_gen.sv
// tb/tb_cmp_flag_gen.sv - directed self-checking bench for cmp_flag_gen
module tb_cmp_flag_gen;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_valid2, sign, flush, out_ready;
  logic [31:0] a, b;
  logic [2:0]  ft;

  logic        in_ready, out_valid, zero, overflow, negative;
  logic [31:0] diff;
  logic [2:0]  ft_out;
  logic        in_ready2, out_valid2, zero2, overflow2, negative2;
  logic [31:0] diff2;
  logic [2:0]  ft_out2;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  logic seen;

  always #5 clk = ~clk;

  cmp_flag_gen #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sign(sign), .ft(ft), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .zero(zero),
    .overflow(overflow), .negative(negative), .ft_out(ft_out)
  );

  cmp_flag_gen #(.WIDTH(32), .CHUNK(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a), .b(b), .sign(sign), .ft(ft), .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready), .diff(diff2), .zero(zero2),
    .overflow(overflow2), .negative(negative2), .ft_out(ft_out2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_b, input logic ts, input logic [2:0] tf);
    a = ta; b = tb_b; sign = ts; ft = tf; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // counts edges after the accept edge until out_valid, capped
  task automatic wait_valid(output int l);
    l = 0;
    while (!out_valid && l < 20) begin
      tick();
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_b,
                        input logic ts, input logic [2:0] tf, input logic [31:0] ed,
                        input logic ez, input logic ev, input logic en);
    int l;
    check({tag, "_in_ready"}, in_ready, 1);
    issue(ta, tb_b, ts, tf);
    wait_valid(l);
    check({tag, "_latency"}, l, 4);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_zero"}, zero, ez);
    check({tag, "_overflow"}, overflow, ev);
    check({tag, "_negative"}, negative, en);
    check({tag, "_ft_out"}, ft_out, tf);
    tick();
    check({tag, "_out_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; sign = 1'b0; flush = 1'b0;
    out_ready = 1'b1; a = '0; b = '0; ft = '0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_flags", {zero, overflow, negative}, 0);
    check("rst_ft_out", ft_out, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    run_op("eq5", 32'd5, 32'd5, 1'b1, FT_EQ, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op("minovf_s", 32'h8000_0000, 32'd1, 1'b1, FT_LT, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    run_op("minovf_u", 32'h8000_0000, 32'd1, 1'b0, FT_LT, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("u1m2", 32'd1, 32'd2, 1'b0, FT_LT, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op("allf_u", 32'hFFFF_FFFF, 32'd1, 1'b0, FT_GEZ, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("allf_s", 32'hFFFF_FFFF, 32'd1, 1'b1, FT_GEZ, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);

    // backpressure: result held, new requests ignored
    out_ready = 1'b0;
    issue(32'd10, 32'd3, 1'b0, FT_GTZ);
    wait_valid(lat);
    check("bp_latency", lat, 4);
    a = 32'd100; b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_diff", diff, 32'd7);
      check("bp_flags", {zero, overflow, negative}, 3'b000);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    run_op("bp_next", 32'd3, 32'd10, 1'b1, FT_LT, 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b1);

    // flush in the second RUN cycle
    issue(32'd1, 32'd2, 1'b0, FT_NEQ);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | out_valid;
      tick();
    end
    check("flush_no_out_valid", seen, 0);
    run_op("post_flush", 32'd7, 32'd3, 1'b0, FT_LEZ, 32'd4, 1'b0, 1'b0, 1'b0);

    // flush beats an accept while idle
    a = 32'd1; b = 32'd1; flush = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle_in_ready", in_ready, 1);
    tick();
    check("flush_idle_no_accept", {in_ready, out_valid}, 2'b10);

    // reset mid-RUN
    issue(32'd9, 32'd2, 1'b1, 3'b011);
    tick();
    rst_n = 1'b0;
    tick();
    check("rstrun_out_valid", out_valid, 0);
    check("rstrun_diff", diff, 0);
    check("rstrun_ft_out", ft_out, 0);
    rst_n = 1'b1;
    tick();
    check("rstrun_in_ready", in_ready, 1);

    // reset mid-DONE
    out_ready = 1'b0;
    issue(32'd2, 32'd9, 1'b1, 3'b101);
    wait_valid(lat);
    check("rstdone_valid", out_valid, 1);
    check("rstdone_pre_negative", negative, 1);
    rst_n = 1'b0;
    tick();
    check("rstdone_out_valid", out_valid, 0);
    check("rstdone_diff", diff, 0);
    check("rstdone_flags", {zero, overflow, negative}, 0);
    check("rstdone_ft_out", ft_out, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    check("rstdone_in_ready", in_ready, 1);

    // single-chunk instance: one RUN cycle
    check("c32_in_ready", in_ready2, 1);
    a = 32'd5; b = 32'd5; sign = 1'b1; ft = FT_EQ; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      tick();
      lat++;
    end
    check("c32_latency", lat, 1);
    check("c32_diff", diff2, 0);
    check("c32_flags", {zero2, overflow2, negative2}, 3'b100);
    check("c32_ft_out", ft_out2, FT_EQ);
    tick();
    check("c32_out_valid_drop", out_valid2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
